// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : apb_pkg
// Brief   : Shared widths, FSM state encoding and command/response records
//           for the APB master bridge.
// Revision: 1.0 - initial release
// ============================================================================
package apb_pkg;

   localparam int c_ADDR_W = 10;
   localparam int c_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_mst_state_t;

   typedef struct packed {
      logic                write;
      logic [c_ADDR_W-1:0] addr;
      logic [c_DATA_W-1:0] wdata;
   } apb_cmd_t;

   typedef struct packed {
      logic [c_DATA_W-1:0] rdata;
      logic                error;
   } apb_rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb_if.sv
`default_nettype none
// ============================================================================
// Module  : apb_if
// Brief   : APB3 bus signal bundle with master and slave views.
// Revision: 1.0 - initial release
// ============================================================================
interface apb_if
   import apb_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W,
   parameter int DATA_W = c_DATA_W
) ();

   logic              PSEL;
   logic [ADDR_W-1:0] PADDR;
   logic              PENABLE;
   logic              PWRITE;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;

   modport master (
      output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY
   );

   modport slave (
      input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY
   );

endinterface
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : apb_wait_timer
// Brief   : Counts ACCESS-phase wait cycles and flags the cycle in which the
//           TIMEOUT_CYCLES-th consecutive wait would occur.
// Revision: 1.0 - initial release
// ============================================================================
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_active,
   input  wire logic i_pready,
   output logic      o_expired
);

   localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [c_CNT_W-1:0] r_count;

   // Held at zero outside ACCESS so every transfer starts a fresh count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (!i_active) begin
         r_count <= '0;
      end else if (!i_pready && (r_count != c_LIMIT)) begin
         r_count <= r_count + c_CNT_W'(1);
      end
   end

   assign o_expired = i_active && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module  : apb_master_bridge
// Brief   : Single-outstanding valid/ready command channel to APB3 master.
//           Optional ACCESS-phase timeout enabled by macro APB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_W         = c_ADDR_W,
   parameter int DATA_W         = c_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  wire logic              PCLK,
   input  wire logic              PRESETn,
   input  wire logic              cmd_valid,
   output logic                   cmd_ready,
   input  wire logic              cmd_write,
   input  wire logic [ADDR_W-1:0] cmd_addr,
   input  wire logic [DATA_W-1:0] cmd_wdata,
   output logic                   rsp_valid,
   input  wire logic              rsp_ready,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_error,
   apb_if.master                  apb
);

   apb_mst_state_t    r_state;
   apb_mst_state_t    w_state_nxt;
   logic              r_cmd_ready;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic              r_pwrite;
   logic [DATA_W-1:0] r_rdata;
   logic              r_error;
   logic              w_load;
   logic              w_capture;
   logic              w_abort;
   logic              w_tmo_expired;

`ifdef APB_TIMEOUT_EN
   logic w_in_access;
   assign w_in_access = (r_state == ACCESS);

   apb_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk       (PCLK),
      .rst_n     (PRESETn),
      .i_active  (w_in_access),
      .i_pready  (apb.PREADY),
      .o_expired (w_tmo_expired)
   );
`else
   localparam int c_unused_tmo = TIMEOUT_CYCLES;
   assign w_tmo_expired = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_capture   = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         IDLE: begin
            if (cmd_valid && r_cmd_ready) begin
               w_load      = 1'b1;
               w_state_nxt = SETUP;
            end
         end
         SETUP: begin
            w_state_nxt = ACCESS;
         end
         ACCESS: begin
            // A slave answering on the expiry cycle still wins.
            if (apb.PREADY) begin
               w_capture   = 1'b1;
               w_state_nxt = RESP;
            end else if (w_tmo_expired) begin
               w_abort     = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // cmd_ready is registered from the next state so it is valid in the very
   // first IDLE cycle after a response handshake.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_cmd_ready <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_pwrite    <= 1'b0;
         r_rdata     <= '0;
         r_error     <= 1'b0;
      end else begin
         r_cmd_ready <= (w_state_nxt == IDLE);
         if (w_load) begin
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_wdata;
            r_pwrite <= cmd_write;
            r_error  <= 1'b0;
         end
         if (w_capture) begin
            r_rdata <= r_pwrite ? '0 : apb.PRDATA;
            r_error <= 1'b0;
         end else if (w_abort) begin
            r_rdata <= '0;
            r_error <= 1'b1;
         end
      end
   end

   assign apb.PSEL    = (r_state == SETUP) || (r_state == ACCESS);
   assign apb.PENABLE = (r_state == ACCESS);
   assign apb.PADDR   = r_paddr;
   assign apb.PWDATA  = r_pwdata;
   assign apb.PWRITE  = r_pwrite;

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = (r_state == RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_master_bridge
// Brief   : Self-checking bench for apb_master_bridge with a memory-backed
//           APB slave and a shadow-memory reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;
   import apb_pkg::*;

   typedef struct {
      apb_cmd_t    cmd;
      int          waits;
      int          hold;
      logic [31:0] exp_rdata;
   } vec_t;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [9:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   logic [31:0] slave_mem [1024];
   logic [31:0] shadow    [1024];
   vec_t        vecs      [8];

   int n_checks = 0;
   int n_pass   = 0;

   apb_if #(.ADDR_W(10), .DATA_W(32)) apb ();

   apb_master_bridge #(
      .ADDR_W         (10),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_error (rsp_error),
      .apb       (apb)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mkv(input logic w, input logic [9:0] a, input logic [31:0] d,
                                input int waits, input int hold, input logic [31:0] exp);
      vec_t v;
      v.cmd.write = w;
      v.cmd.addr  = a;
      v.cmd.wdata = d;
      v.waits     = waits;
      v.hold      = hold;
      v.exp_rdata = exp;
      return v;
   endfunction

   task automatic wait_accept();
      int n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge PCLK);
         n++;
      end
      chk("accept_wait", 64'(n < 20), 64'd1);
   endtask

   // One full transfer: the slave answers after `waits` wait states and the
   // consumer withholds rsp_ready for `hold` cycles.
   task automatic xfer(input logic w, input logic [9:0] a, input logic [31:0] wd,
                       input int waits, input int hold, input logic [31:0] exp_rd);
      int n;
      bit stable;
      rsp_ready = (hold == 0);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = wd;
      wait_accept();
      @(negedge PCLK);
      cmd_valid  = 1'b0;
      cmd_write  = ~w;
      cmd_addr   = ~a;
      cmd_wdata  = ~wd;
      apb.PREADY = 1'($urandom);
      chk("setup_ctrl", {apb.PSEL, apb.PENABLE, cmd_ready, rsp_valid}, 4'b1000);
      chk("setup_cmd", {apb.PWRITE, apb.PADDR}, {w, a});
      if (w) chk("setup_wdata", apb.PWDATA, wd);
      n = 0;
      stable = 1'b1;
      @(negedge PCLK);
      while (apb.PSEL && apb.PENABLE && n <= waits + 20) begin
         if (apb.PADDR !== a || apb.PWRITE !== w || (w && apb.PWDATA !== wd) || cmd_ready)
            stable = 1'b0;
         apb.PREADY = (n == waits);
         apb.PRDATA = $urandom;
         if (n == waits) begin
            if (apb.PWRITE) slave_mem[apb.PADDR] = apb.PWDATA;
            else apb.PRDATA = slave_mem[apb.PADDR];
         end
         @(negedge PCLK);
         n++;
      end
      apb.PREADY = 1'($urandom);
      chk("access_len", 64'(n), 64'(waits + 1));
      chk("access_stable", 64'(stable), 64'd1);
      chk("rsp_ctrl", {rsp_valid, apb.PSEL, apb.PENABLE, cmd_ready}, 4'b1000);
      chk("rsp_data", {rsp_error, rsp_rdata}, {1'b0, exp_rd});
      if (hold > 0) begin
         stable    = 1'b1;
         cmd_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge PCLK);
            if (!rsp_valid || rsp_rdata !== exp_rd || cmd_ready || apb.PSEL) stable = 1'b0;
         end
         chk("rsp_hold", 64'(stable), 64'd1);
         cmd_valid = 1'b0;
         rsp_ready = 1'b1;
      end
      @(negedge PCLK);
      chk("rsp_done", {rsp_valid, cmd_ready, apb.PSEL}, 3'b010);
   endtask

   initial begin
      int accepts[$];
      int overlap, n_access, bad, k, seen, n;
      bit acc;
      logic        w;
      logic [9:0]  a;
      logic [31:0] d;

      for (int i = 0; i < 1024; i++) begin
         slave_mem[i] = 32'h0;
         shadow[i]    = 32'h0;
      end
      PRESETn    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_write  = 1'b0;
      cmd_addr   = '0;
      cmd_wdata  = '0;
      rsp_ready  = 1'b0;
      apb.PREADY = 1'b0;
      apb.PRDATA = '0;

      // Reset state
      repeat (3) @(negedge PCLK);
      chk("rst_ctrl", {apb.PSEL, apb.PENABLE, apb.PWRITE, cmd_ready, rsp_valid, rsp_error}, 6'b0);
      chk("rst_data", {apb.PADDR, apb.PWDATA, rsp_rdata}, 74'h0);
      PRESETn = 1'b1;
      #1;
      chk("rst_ready_pre", 64'(cmd_ready), 64'd0);
      @(negedge PCLK);
      chk("rst_ready_post", 64'(cmd_ready), 64'd1);

      // Directed table
      vecs[0] = mkv(1'b1, 10'h3C4, 32'hDEADBEEF, 0, 0, 32'h0);
      vecs[1] = mkv(1'b1, 10'h010, 32'h12345678, 1, 0, 32'h0);
      vecs[2] = mkv(1'b0, 10'h010, 32'h0,        3, 0, 32'h12345678);
      vecs[3] = mkv(1'b0, 10'h010, 32'h0,        0, 10, 32'h12345678);
      vecs[4] = mkv(1'b0, 10'h3C4, 32'h0,        2, 1, 32'hDEADBEEF);
      vecs[5] = mkv(1'b0, 10'h155, 32'h0,        0, 0, 32'h0);
      vecs[6] = mkv(1'b1, 10'h3FF, 32'hA5A5A5A5, 4, 2, 32'h0);
      vecs[7] = mkv(1'b0, 10'h3FF, 32'h0,        0, 0, 32'hA5A5A5A5);
      for (int i = 0; i < 8; i++) begin
         xfer(vecs[i].cmd.write, vecs[i].cmd.addr, vecs[i].cmd.wdata,
              vecs[i].waits, vecs[i].hold, vecs[i].exp_rdata);
         if (vecs[i].cmd.write) shadow[vecs[i].cmd.addr] = vecs[i].cmd.wdata;
      end

      // Back-to-back writes with cmd_valid held and zero-wait slave
      rsp_ready  = 1'b1;
      apb.PREADY = 1'b1;
      cmd_valid  = 1'b1;
      cmd_write  = 1'b1;
      cmd_addr   = 10'h100;
      cmd_wdata  = 32'hB0;
      overlap = 0; n_access = 0; bad = 0; k = 0;
      for (int cyc = 0; cyc < 24; cyc++) begin
         if (cmd_ready && (apb.PSEL || rsp_valid)) overlap++;
         if (apb.PSEL && apb.PENABLE) begin
            n_access++;
            if (apb.PADDR !== 10'(32'h100 + k - 1)) bad++;
         end
         acc = cmd_valid && cmd_ready;
         if (acc) begin
            accepts.push_back(cyc);
            k++;
         end
         @(negedge PCLK);
         if (acc) begin
            cmd_addr  = 10'(32'h100 + k);
            cmd_wdata = 32'hB0 + 32'(k);
            cmd_valid = (k < 5);
         end
      end
      chk("b2b_count", 64'(accepts.size()), 64'd5);
      for (int i = 1; i < accepts.size(); i++)
         chk("b2b_interval", 64'(accepts[i] - accepts[i-1]), 64'd4);
      chk("b2b_overlap", 64'(overlap), 64'd0);
      chk("b2b_access", 64'(n_access), 64'd5);
      chk("b2b_addr", 64'(bad), 64'd0);

      // Reset pulse in the middle of ACCESS
      apb.PREADY = 1'b0;
      cmd_valid  = 1'b1;
      cmd_write  = 1'b0;
      cmd_addr   = 10'h2AA;
      wait_accept();
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(negedge PCLK);
      chk("midrst_pre", {apb.PSEL, apb.PENABLE}, 2'b11);
      #2;
      PRESETn = 1'b0;
      #1;
      chk("midrst_ctrl", {apb.PSEL, apb.PENABLE, rsp_valid, cmd_ready}, 4'b0);
      chk("midrst_addr", 64'(apb.PADDR), 64'd0);
      @(negedge PCLK);
      apb.PREADY = 1'b1;
      PRESETn    = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge PCLK);
         if (rsp_valid || apb.PSEL) seen++;
      end
      chk("midrst_no_rsp", 64'(seen), 64'd0);
      xfer(1'b0, 10'h3C4, 32'h0, 1, 0, shadow[10'h3C4]);

`ifdef APB_TIMEOUT_EN
      // Slave never answers: abort after 16 wait cycles
      xfer(1'b1, 10'h0AB, 32'hCAFEF00D, 0, 0, 32'h0);
      shadow[10'h0AB] = 32'hCAFEF00D;
      rsp_ready  = 1'b1;
      apb.PREADY = 1'b0;
      apb.PRDATA = 32'hFFFFFFFF;
      cmd_valid  = 1'b1;
      cmd_write  = 1'b0;
      cmd_addr   = 10'h0AB;
      wait_accept();
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(negedge PCLK);
      n = 0;
      while (apb.PSEL && apb.PENABLE && n < 40) begin
         @(negedge PCLK);
         n++;
      end
      chk("tmo_len", 64'(n), 64'd16);
      chk("tmo_rsp", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, 1'b1, 32'h0});
      @(negedge PCLK);
      // Slave answers exactly on the last allowed cycle
      xfer(1'b0, 10'h0AB, 32'h0, 15, 0, 32'hCAFEF00D);
`endif

      // Randomised transfers against the shadow memory
      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom);
         a = 10'($urandom_range(0, 15));
         d = $urandom;
         xfer(w, a, d, $urandom_range(0, 5), $urandom_range(0, 3), w ? 32'h0 : shadow[a]);
         if (w) shadow[a] = d;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
